// File: rtl/tetris_game_seq.sv
// Tetris game sequencer: spawn, gravity, moves, lock handshakes and row clearing.
// Optional TETRIS_SPEEDUP_EN shortens the gravity period as cleared lines grow.
module tetris_game_seq #(
   parameter int BOARD_W       = 10,
   parameter int BOARD_H       = 20,
   parameter int ADDR_W        = 8,
   parameter int CELL_W        = 6,
   parameter int GRAVITY_TICKS = 25_000_000,
   parameter int NUM_PIECES    = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic              left,
   input  logic              right,
   input  logic              rotate,
   input  logic              soft_drop,
   output logic              chk_start,
   output logic [4:0]        chk_x,
   output logic [5:0]        chk_y,
   output logic [1:0]        chk_rot,
   input  logic              chk_done,
   input  logic              chk_hit,
   output logic              drw_start,
   output logic [4:0]        drw_x,
   output logic [5:0]        drw_y,
   output logic [1:0]        drw_rot,
   output logic              drw_clear,
   input  logic              drw_done,
   output logic              lock_start,
   input  logic              lock_done,
   output logic [2:0]        piece,
   output logic              ram_own,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CELL_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [CELL_W-1:0] ram_rdata,
   output logic [15:0]       score,
   output logic [9:0]        lines,
   output logic              game_over
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_SPAWN, S_DRAW, S_WAIT, S_CHECK,
      S_ERASE, S_LOCK, S_SCAN, S_SHIFT, S_SCORE, S_OVER
   } state_t;

   localparam int CELLS = BOARD_W * BOARD_H;
   localparam int GW    = $clog2(GRAVITY_TICKS + 1);
   localparam int RW    = $clog2(BOARD_H);
   localparam int CW    = $clog2(BOARD_W + 1);
   localparam int X0    = (BOARD_W - 4) / 2;

   state_t            state_q, state_d;
   logic              busy_q, busy_d, down_q, down_d, tick_q, tick_d;
   logic              ev_vld_q, ev_vld_d, phase_q, phase_d;
   logic [1:0]        ev_q, ev_d, rot_q, rot_d, crot_q, crot_d;
   logic [4:0]        x_q, x_d, cx_q, cx_d;
   logic [5:0]        y_q, y_d, cy_q, cy_d;
   logic [2:0]        piece_q, piece_d, cleared_q, cleared_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic [3:0]        prev_q, prev_d, ins, rise;
   logic [GW-1:0]     grav_q, grav_d, period;
   logic [ADDR_W-1:0] ptr_q, ptr_d, scan_addr, row_end;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [15:0]       score_q, score_d;
   logic [9:0]        lines_q, lines_d;
   logic [16:0]       sum;
   logic [3:0]        add;
   logic              spawn_go;

`ifdef TETRIS_SPEEDUP_EN
   logic [GW-1:0]     period_q, period_d;
   logic [31:0]       red;
   assign period = period_q;
`else
   assign period = GW'(GRAVITY_TICKS);
`endif

   assign ins       = {soft_drop, right, left, rotate};
   assign rise      = ins & ~prev_q;
   assign scan_addr = ADDR_W'(row_q) * ADDR_W'(BOARD_W) + ADDR_W'(col_q);
   assign row_end   = ADDR_W'(row_q) * ADDR_W'(BOARD_W) + ADDR_W'(BOARD_W - 1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         down_q    <= 1'b0;
         tick_q    <= 1'b0;
         ev_vld_q  <= 1'b0;
         ev_q      <= '0;
         phase_q   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         rot_q     <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         crot_q    <= '0;
         piece_q   <= '0;
         cleared_q <= '0;
         lfsr_q    <= 8'h01;
         prev_q    <= '0;
         grav_q    <= '0;
         ptr_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         score_q   <= '0;
         lines_q   <= '0;
`ifdef TETRIS_SPEEDUP_EN
         period_q  <= GW'(GRAVITY_TICKS);
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         down_q    <= down_d;
         tick_q    <= tick_d;
         ev_vld_q  <= ev_vld_d;
         ev_q      <= ev_d;
         phase_q   <= phase_d;
         x_q       <= x_d;
         y_q       <= y_d;
         rot_q     <= rot_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         crot_q    <= crot_d;
         piece_q   <= piece_d;
         cleared_q <= cleared_d;
         lfsr_q    <= lfsr_d;
         prev_q    <= prev_d;
         grav_q    <= grav_d;
         ptr_q     <= ptr_d;
         row_q     <= row_d;
         col_q     <= col_d;
         score_q   <= score_d;
         lines_q   <= lines_d;
`ifdef TETRIS_SPEEDUP_EN
         period_q  <= period_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      down_d    = down_q;
      tick_d    = tick_q;
      ev_vld_d  = ev_vld_q;
      ev_d      = ev_q;
      phase_d   = phase_q;
      x_d       = x_q;
      y_d       = y_q;
      rot_d     = rot_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      crot_d    = crot_q;
      piece_d   = piece_q;
      cleared_d = cleared_q;
      prev_d    = ins;
      grav_d    = grav_q;
      ptr_d     = ptr_q;
      row_d     = row_q;
      col_d     = col_q;
      score_d   = score_q;
      lines_d   = lines_q;
      spawn_go  = 1'b0;
      add       = 4'd0;
      sum       = '0;
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef TETRIS_SPEEDUP_EN
      period_d  = period_q;
      red       = '0;
`endif
      case (state_q)
         S_IDLE, S_OVER: if (go) begin
            state_d  = S_CLEAR;
            ptr_d    = '0;
            score_d  = '0;
            lines_d  = '0;
            ev_vld_d = 1'b0;
            tick_d   = 1'b0;
            grav_d   = '0;
         end
         S_CLEAR: begin
            if (ptr_q == ADDR_W'(CELLS - 1)) begin
               ptr_d    = '0;
               spawn_go = 1'b1;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         S_SPAWN: begin
            if (!busy_q) busy_d = 1'b1;
            else if (chk_done) begin
               busy_d  = 1'b0;
               state_d = chk_hit ? S_OVER : S_DRAW;
            end
         end
         S_DRAW: begin
            if (!busy_q) busy_d = 1'b1;
            else if (drw_done) begin
               busy_d  = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (grav_q >= period - GW'(1)) begin
               grav_d = '0;
               tick_d = 1'b1;
            end else begin
               grav_d = grav_q + GW'(1);
            end
            cx_d   = x_q;
            cy_d   = y_q;
            crot_d = rot_q;
            down_d = 1'b0;
            // Queued input wins over gravity; edge moves off the board are dropped.
            if (ev_vld_q) begin
               ev_vld_d = 1'b0;
               if (ev_q == 2'd0) begin
                  crot_d  = rot_q + 2'd1;
                  state_d = S_CHECK;
               end else if (ev_q == 2'd1) begin
                  cx_d = x_q - 5'd1;
                  if (x_q != 5'd0) state_d = S_CHECK;
               end else if (ev_q == 2'd2) begin
                  cx_d = x_q + 5'd1;
                  if (x_q < 5'(BOARD_W - 1)) state_d = S_CHECK;
               end else begin
                  cy_d    = y_q + 6'd1;
                  down_d  = 1'b1;
                  state_d = S_CHECK;
               end
            end else if (tick_q) begin
               tick_d  = 1'b0;
               cy_d    = y_q + 6'd1;
               down_d  = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!busy_q) busy_d = 1'b1;
            else if (chk_done) begin
               busy_d = 1'b0;
               if (!chk_hit) state_d = S_ERASE;
               else state_d = down_q ? S_LOCK : S_WAIT;
            end
         end
         S_ERASE: begin
            if (!busy_q) busy_d = 1'b1;
            else if (drw_done) begin
               busy_d  = 1'b0;
               x_d     = cx_q;
               y_d     = cy_q;
               rot_d   = crot_q;
               state_d = S_DRAW;
            end
         end
         S_LOCK: begin
            if (!busy_q) busy_d = 1'b1;
            else if (lock_done) begin
               busy_d    = 1'b0;
               row_d     = RW'(BOARD_H - 1);
               col_d     = '0;
               cleared_d = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            // rdata lags the address by one cycle, so col_q-1 is being tested.
            if (col_q != '0 && ram_rdata == '0) begin
               col_d = '0;
               if (row_q == '0) state_d = S_SCORE;
               else row_d = row_q - RW'(1);
            end else if (col_q == CW'(BOARD_W)) begin
               col_d   = '0;
               ptr_d   = row_end;
               phase_d = 1'b0;
               state_d = S_SHIFT;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         S_SHIFT: begin
            if (ptr_q < ADDR_W'(BOARD_W)) begin
               if (ptr_q == '0) begin
                  if (lines_q != 10'h3FF) lines_d = lines_q + 10'd1;
                  if (cleared_q != 3'd7) cleared_d = cleared_q + 3'd1;
                  state_d = S_SCAN;
               end else begin
                  ptr_d = ptr_q - ADDR_W'(1);
               end
            end else if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               ptr_d   = ptr_q - ADDR_W'(1);
            end
         end
         S_SCORE: begin
            case (cleared_q)
               3'd0:    add = 4'd0;
               3'd1:    add = 4'd1;
               3'd2:    add = 4'd3;
               3'd3:    add = 4'd5;
               default: add = 4'd8;
            endcase
            sum      = {1'b0, score_q} + {13'd0, add};
            score_d  = sum[16] ? 16'hFFFF : sum[15:0];
            spawn_go = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (spawn_go) begin
         state_d = S_SPAWN;
         busy_d  = 1'b0;
         piece_d = 3'(lfsr_q % 8'(NUM_PIECES));
         x_d     = 5'(X0);
         y_d     = '0;
         rot_d   = '0;
         cx_d    = 5'(X0);
         cy_d    = '0;
         crot_d  = '0;
`ifdef TETRIS_SPEEDUP_EN
         red = (32'(lines_q) / 32'd10) * 32'(GRAVITY_TICKS / 16);
         if (red + 32'(GRAVITY_TICKS / 8) >= 32'(GRAVITY_TICKS))
            period_d = GW'(GRAVITY_TICKS / 8);
         else
            period_d = GW'(32'(GRAVITY_TICKS) - red);
`endif
      end
      if (state_q != S_OVER && !ev_vld_d && rise != 4'd0) begin
         ev_vld_d = 1'b1;
         if (rise[0]) ev_d = 2'd0;
         else if (rise[1]) ev_d = 2'd1;
         else if (rise[2]) ev_d = 2'd2;
         else ev_d = 2'd3;
      end
   end

   always_comb begin
      chk_start  = (state_q == S_SPAWN || state_q == S_CHECK) && !busy_q;
      chk_x      = cx_q;
      chk_y      = cy_q;
      chk_rot    = crot_q;
      drw_start  = (state_q == S_DRAW || state_q == S_ERASE) && !busy_q;
      drw_x      = x_q;
      drw_y      = y_q;
      drw_rot    = rot_q;
      drw_clear  = state_q == S_ERASE;
      lock_start = state_q == S_LOCK && !busy_q;
      piece      = piece_q;
      ram_own    = state_q == S_CLEAR || state_q == S_SCAN || state_q == S_SHIFT;
      ram_addr   = ptr_q;
      ram_wdata  = '0;
      ram_wren   = state_q == S_CLEAR;
      if (state_q == S_SCAN) begin
         ram_addr = scan_addr;
      end else if (state_q == S_SHIFT) begin
         if (ptr_q < ADDR_W'(BOARD_W)) begin
            ram_wren = 1'b1;
         end else if (!phase_q) begin
            ram_addr = ptr_q - ADDR_W'(BOARD_W);
         end else begin
            ram_wren  = 1'b1;
            ram_wdata = ram_rdata;
         end
      end
      score     = score_q;
      lines     = lines_q;
      game_over = state_q == S_OVER;
   end

endmodule

// File: tb/tb_tetris_game_seq.sv
// Directed bench for tetris_game_seq with small collision/draw/lock/RAM models.
module tb_tetris_game_seq;
   localparam int W  = 10;
   localparam int H  = 20;
   localparam int GT = 8;

   logic clk = 0, reset_n = 0, go = 0;
   logic left = 0, right = 0, rotate = 0, soft_drop = 0;
   logic chk_start, chk_done = 0, chk_hit = 0;
   logic [4:0] chk_x, drw_x;
   logic [5:0] chk_y, drw_y;
   logic [1:0] chk_rot, drw_rot;
   logic drw_start, drw_clear, drw_done = 0, lock_start, lock_done = 0;
   logic [2:0] piece;
   logic ram_own, ram_wren;
   logic [7:0] ram_addr;
   logic [5:0] ram_wdata, ram_rdata = 0;
   logic [15:0] score;
   logic [9:0] lines;
   logic game_over;
   logic [5:0] mem [0:W*H-1];
   bit hit_all = 0;
   int floor_y = 63, fill_mode = 0, fill_id = 0, fill_used = 0;
   int checks = 0, failures = 0;

   tetris_game_seq #(.BOARD_W(W), .BOARD_H(H), .ADDR_W(8), .CELL_W(6),
      .GRAVITY_TICKS(GT), .NUM_PIECES(7)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
      .rotate(rotate), .soft_drop(soft_drop),
      .chk_start(chk_start), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
      .chk_done(chk_done), .chk_hit(chk_hit),
      .drw_start(drw_start), .drw_x(drw_x), .drw_y(drw_y), .drw_rot(drw_rot),
      .drw_clear(drw_clear), .drw_done(drw_done),
      .lock_start(lock_start), .lock_done(lock_done), .piece(piece),
      .ram_own(ram_own), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wren(ram_wren), .ram_rdata(ram_rdata),
      .score(score), .lines(lines), .game_over(game_over));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      chk_done  <= chk_start;
      chk_hit   <= chk_start && (hit_all || int'(chk_y) > floor_y);
      drw_done  <= drw_start;
      lock_done <= lock_start;
   end

   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < W*H; i++) mem[i] <= 6'h2A;
      end else if (lock_start && fill_mode != 0 && fill_id != fill_used) begin
         fill_used <= fill_id;
         for (int c = 0; c < W; c++) begin
            if (fill_mode == 1) begin
               mem[19*W+c] <= 6'(c + 1);
               mem[18*W+c] <= (c == 0) ? 6'd0 : 6'(c + 20);
            end else begin
               for (int r = 16; r < 20; r++) mem[r*W+c] <= 6'd7;
               mem[15*W+c] <= (c == 5) ? 6'd0 : 6'(c + 40);
            end
         end
      end else if (ram_own && ram_wren) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= (int'(ram_addr) < W*H) ? mem[ram_addr] : 6'd0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press(input int which);
      @(negedge clk);
      case (which)
         0: rotate = 1;
         1: left = 1;
         2: right = 1;
         default: soft_drop = 1;
      endcase
      repeat (2) @(negedge clk);
      rotate = 0; left = 0; right = 0; soft_drop = 0;
   endtask

   task automatic wait_chk(input int xv, input int yv, input int rv,
                           input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (chk_start && (xv < 0 || int'(chk_x) == xv) &&
             (yv < 0 || int'(chk_y) == yv) && (rv < 0 || int'(chk_rot) == rv)) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_lock(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (lock_start) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int cnt, bad, seen;
      repeat (3) @(negedge clk);
      check("rst_chk_start", chk_start, 0);
      check("rst_drw_start", drw_start, 0);
      check("rst_lock_start", lock_start, 0);
      check("rst_ram_own", ram_own, 0);
      check("rst_ram_wren", ram_wren, 0);
      check("rst_game_over", game_over, 0);
      check("rst_score", score, 0);
      check("rst_lines", lines, 0);
      check("rst_piece", piece, 0);
      check("rst_args", {chk_x, chk_y, chk_rot, drw_x, drw_y, drw_rot, drw_clear}, 0);
      check("rst_ram", {ram_addr, ram_wdata}, 0);
      reset_n = 1;

      @(negedge clk); go = 1;
      @(negedge clk); go = 0;
      for (int k = 0; k < 10 && !ram_wren; k++) @(negedge clk);
      cnt = 0;
      while (ram_wren && ram_own && ram_wdata == 0 && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      check("clear_cycles", cnt, W*H);
      check("spawn_chk_start", chk_start, 1);
      check("spawn_pos", {chk_x, chk_y, chk_rot}, {5'd3, 6'd0, 2'd0});
      check("piece_range", piece < 3'd7, 1);
      bad = 0;
      for (int i = 0; i < W*H; i++) if (mem[i] !== 6'd0) bad++;
      check("board_cleared", bad, 0);

      wait_chk(3, 1, 0, 60, ok);
      check("gravity_y1", ok, 1);
      wait_chk(3, 2, 0, 60, ok);
      check("gravity_y2", ok, 1);

      press(0);
      wait_chk(3, -1, 1, 60, ok);
      check("rotate_chk", ok, 1);
      repeat (10) @(negedge clk);

      for (int t = 2; t >= 0; t--) begin
         press(1);
         wait_chk(t, -1, -1, 60, ok);
         check("left_chk", ok, 1);
         repeat (10) @(negedge clk);
      end

      press(1);
      bad = 0; seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (chk_start && chk_x != 5'd0) bad++;
         if (chk_start && chk_x == 5'd0) seen++;
      end
      check("left_edge_nochk", bad, 0);
      check("left_edge_x0", seen > 0, 1);

      press(2);
      wait_chk(1, -1, -1, 60, ok);
      check("right_chk", ok, 1);
      repeat (10) @(negedge clk);

      fill_mode = 1; fill_id++; floor_y = 0;
      wait_lock(ok);
      check("lockA_start", ok, 1);
      wait_chk(3, 0, 0, 3000, ok);
      check("lockA_respawn", ok, 1);
      check("lockA_lines", lines, 1);
      check("lockA_score", score, 1);
      bad = 0;
      for (int c = 0; c < W; c++)
         if (mem[19*W+c] !== ((c == 0) ? 6'd0 : 6'(c + 20))) bad++;
      for (int i = 0; i < 19*W; i++) if (mem[i] !== 6'd0) bad++;
      check("lockA_board", bad, 0);

      fill_mode = 2; fill_id++;
      wait_lock(ok);
      check("lockB_start", ok, 1);
      wait_chk(3, 0, 0, 5000, ok);
      check("lockB_respawn", ok, 1);
      check("lockB_lines", lines, 5);
      check("lockB_score", score, 9);
      bad = 0;
      for (int c = 0; c < W; c++)
         if (mem[19*W+c] !== ((c == 5) ? 6'd0 : 6'(c + 40))) bad++;
      for (int i = 0; i < 19*W; i++) if (mem[i] !== 6'd0) bad++;
      check("lockB_board", bad, 0);

      fill_mode = 1; fill_id++;
      wait_lock(ok);
      check("lockC_start", ok, 1);
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (ram_own && ram_wren) begin
            ok = 1;
            break;
         end
      end
      check("shift_write_seen", ok, 1);
      reset_n = 0;
      @(negedge clk);
      check("midrst_own_wren", {ram_own, ram_wren}, 0);
      check("midrst_score_lines", {score, lines}, 0);
      check("midrst_starts", {chk_start, drw_start, lock_start, game_over}, 0);
      check("midrst_addr", ram_addr, 0);

      reset_n = 1; hit_all = 1; floor_y = 63;
      @(negedge clk); go = 1;
      @(negedge clk); go = 0;
      wait_chk(3, 0, 0, 400, ok);
      check("over_spawn_chk", ok, 1);
      check("over_not_yet", game_over, 0);
      repeat (2) @(negedge clk);
      check("game_over_set", game_over, 1);
      press(1);
      hit_all = 0;
      repeat (3) @(negedge clk);
      check("game_over_hold", game_over, 1);
      go = 1;
      @(negedge clk); go = 0;
      check("restart_go_clr", game_over, 0);
      check("restart_clear", ram_own, 1);
      wait_chk(3, 0, 0, 400, ok);
      check("restart_spawn", ok, 1);
      wait_chk(-1, -1, -1, 60, ok);
      check("restart_next_chk", ok, 1);
      check("over_edge_dropped", chk_x, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
